// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32M divide-group constants, FSM state type and decode helpers
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OP_RTYPE      = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } div_state_t;

  function automatic logic is_signed_div(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_rem_div(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-divide step on the {rem,quo} pair
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] rq_in,
  input  logic [XLEN-1:0]   divisor,
  output logic [2*XLEN-1:0] rq_out
);

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] quo_sh;

  // shifted < 2*divisor, so a non-negative trial always fits in XLEN bits
  assign shifted = rq_in[2*XLEN-1:XLEN-1];
  assign quo_sh  = {rq_in[XLEN-2:0], 1'b0};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    rq_out = {shifted[XLEN-1:0], quo_sh};
    if (!trial[XLEN]) begin
      rq_out = {trial[XLEN-1:0], quo_sh | {{(XLEN-1){1'b0}}, 1'b1}};
    end
  end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative RV32M DIV/DIVU/REM/REMU sequencer; DIV_RADIX4_EN selects two steps per cycle
module div_seq
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_EX,
  input  logic [2:0]      funct3_EX,
  input  logic [XLEN-1:0] a_EX,
  input  logic [XLEN-1:0] b_EX,
  input  logic            kill,
  output logic            stall_EX,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

`ifdef DIV_RADIX4_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif
  localparam int N  = XLEN / STEPS;
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, res_q;
  logic            q_sign_q, a_sign_q;
  logic [CW-1:0]   cnt_q;

  logic            sgn_in, a_neg, b_neg, ovf_in;
  logic [XLEN-1:0] a_abs, b_abs, q_fix, r_fix;
  logic [2*XLEN-1:0] rq_next;

  assign sgn_in = is_signed_div(funct3_EX);
  assign a_neg  = sgn_in & a_EX[XLEN-1];
  assign b_neg  = sgn_in & b_EX[XLEN-1];
  assign a_abs  = a_neg ? -a_EX : a_EX;
  assign b_abs  = b_neg ? -b_EX : b_EX;
  assign ovf_in = sgn_in && (a_EX == MIN_INT) && (b_EX == '1);

`ifdef DIV_RADIX4_EN
  logic [2*XLEN-1:0] rq_mid;
  div_step #(.XLEN(XLEN)) u_step0 (.rq_in({rem_q, quo_q}), .divisor(dvs_q), .rq_out(rq_mid));
  div_step #(.XLEN(XLEN)) u_step1 (.rq_in(rq_mid), .divisor(dvs_q), .rq_out(rq_next));
`else
  div_step #(.XLEN(XLEN)) u_step0 (.rq_in({rem_q, quo_q}), .divisor(dvs_q), .rq_out(rq_next));
`endif

  assign q_fix = q_sign_q ? -quo_q : quo_q;
  assign r_fix = a_sign_q ? -rem_q : rem_q;

  assign stall_EX = ~kill & (((state == S_IDLE) & start_EX) | (state == S_RUN) | (state == S_FIX));
  assign busy     = (state != S_IDLE);
  assign result   = res_q;

  // res_q is only non-zero during the DONE cycle, so result reads 0 whenever done is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      f3_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      q_sign_q <= 1'b0;
      a_sign_q <= 1'b0;
      cnt_q    <= '0;
      done     <= 1'b0;
    end else if (kill) begin
      state <= S_IDLE;
      res_q <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_EX) begin
            f3_q     <= funct3_EX;
            rem_q    <= '0;
            quo_q    <= a_abs;
            dvs_q    <= b_abs;
            q_sign_q <= a_neg ^ b_neg;
            a_sign_q <= a_neg;
            cnt_q    <= CW'(N);
            if (b_EX == '0) begin
              res_q <= is_rem_div(funct3_EX) ? a_EX : '1;
              done  <= 1'b1;
              state <= S_DONE;
            end else if (ovf_in) begin
              res_q <= is_rem_div(funct3_EX) ? '0 : MIN_INT;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          {rem_q, quo_q} <= rq_next;
          cnt_q          <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          res_q <= is_rem_div(f3_q) ? r_fix : q_fix;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          res_q <= '0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed vector bench for div_seq; honours DIV_RADIX4_EN for latency
module tb_div_seq;

  localparam int XLEN = 32;
`ifdef DIV_RADIX4_EN
  localparam int LAT     = 18;
  localparam int RST_CYC = 10;
`else
  localparam int LAT     = 34;
  localparam int RST_CYC = 20;
`endif

  logic            clk = 1'b0;
  logic            rst_n, start_EX, kill;
  logic [2:0]      funct3_EX;
  logic [XLEN-1:0] a_EX, b_EX;
  logic            stall_EX, busy, done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  div_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start_EX(start_EX), .funct3_EX(funct3_EX),
    .a_EX(a_EX), .b_EX(b_EX), .kill(kill), .stall_EX(stall_EX),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int cyc, stalls, bad_res;
    bit seen;
    @(negedge clk);
    funct3_EX = f3; a_EX = a; b_EX = b; start_EX = 1'b1;
    cyc = 0; stalls = 0; bad_res = 0; seen = 1'b0;
    while (!seen && cyc <= 100) begin
      #1;
      if (stall_EX) stalls++;
      if (done) begin
        seen = 1'b1;
        check({name, " done_cycle"}, cyc, exp_lat);
        check({name, " result"}, result, exp_res);
      end else if (result !== '0) begin
        bad_res++;
      end
      if (!seen) begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) begin
          a_EX = ~a; b_EX = ~b;
        end
      end
    end
    start_EX = 1'b0;
    check({name, " done_seen"}, seen, 1);
    check({name, " stall_cycles"}, stalls, exp_lat);
    check({name, " result_zero_when_idle"}, bad_res, 0);
  endtask

  initial begin
    int dcount;

    vecs.push_back('{"divu_100_7",   3'b101, 32'd100,        32'd7,          32'd14,         LAT});
    vecs.push_back('{"remu_100_7",   3'b111, 32'd100,        32'd7,          32'd2,          LAT});
    vecs.push_back('{"div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  LAT});
    vecs.push_back('{"rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  LAT});
    vecs.push_back('{"div_5_0",      3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{"remu_5_0",     3'b111, 32'd5,          32'd0,          32'd5,          1});
    vecs.push_back('{"div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    vecs.push_back('{"rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
    vecs.push_back('{"divu_max_1",   3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  LAT});
    vecs.push_back('{"divu_max_max1",3'b101, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          LAT});
    vecs.push_back('{"remu_max_max1",3'b111, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          LAT});
    vecs.push_back('{"div_7_m2",     3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  LAT});
    vecs.push_back('{"rem_7_m2",     3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          LAT});
    vecs.push_back('{"rem_m100_7",   3'b110, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  LAT});
    vecs.push_back('{"div_min_2",    3'b100, 32'h8000_0000,  32'd2,          32'hC000_0000,  LAT});
    vecs.push_back('{"divu_min_m1",  3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          LAT});
    vecs.push_back('{"remu_min_m1",  3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  LAT});
    vecs.push_back('{"divu_0_5",     3'b101, 32'd0,          32'd5,          32'd0,          LAT});

    rst_n = 1'b0; start_EX = 1'b0; kill = 1'b0; funct3_EX = 3'b000; a_EX = '0; b_EX = '0;
    repeat (2) @(negedge clk);
    check("reset stall_EX", stall_EX, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle busy", busy, 0);
    check("idle stall_EX", stall_EX, 0);

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

    // kill at cycle 10 of a DIVU, then a fresh op must run normally
    @(negedge clk);
    funct3_EX = 3'b101; a_EX = 32'd100; b_EX = 32'd7; start_EX = 1'b1;
    repeat (10) @(negedge clk);
    kill = 1'b1; start_EX = 1'b0;
    #1;
    check("kill stall_EX", stall_EX, 0);
    check("kill busy_before_edge", busy, 1);
    @(negedge clk);
    kill = 1'b0;
    #1;
    check("kill busy_after", busy, 0);
    dcount = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("kill no_done", dcount, 0);
    run_op("after_kill_divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, LAT);

    // asynchronous reset mid-operation
    @(negedge clk);
    funct3_EX = 3'b100; a_EX = 32'd100; b_EX = 32'd7; start_EX = 1'b1;
    repeat (RST_CYC) @(negedge clk);
    #1;
    check("prereset busy", busy, 1);
    rst_n = 1'b0; start_EX = 1'b0;
    #1;
    check("async_rst stall_EX", stall_EX, 0);
    check("async_rst busy", busy, 0);
    check("async_rst done", done, 0);
    check("async_rst result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst_divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, LAT);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for the RV32M divide group (DIV, DIVU, REM, REMU) in the 3-stage CPU. It sits beside the EX-stage ALU, which handles only single-cycle ops. It accepts one divide request from EX and stalls the pipeline while it runs an iterative restoring divide. It then presents the result for exactly one cycle for writeback.

## Interface
- XLEN, 32, operand/result width; must be even and ≥ 4.
- clk  in  1  system clock; everything is rising-edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- start_EX  in  1  EX holds a divide-group instruction; level, held until done.
- funct3_EX  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; sampled with start.
- a_EX  in  XLEN  dividend (rs1), sampled with start.
- b_EX  in  XLEN  divisor (rs2), sampled with start.
- kill  in  1  synchronous flush; abandons any operation.
- stall_EX  out  1  freeze PC/IF/EX registers this cycle.
- busy  out  1  state is not IDLE.
- done  out  1  result valid this cycle; single-cycle pulse.
- result  out  XLEN  quotient or remainder; value is 0 when done is low.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE with start_EX=1 and kill=0:
  - Latch funct3, |a|, |b| (signed ops only), sign of quotient, sign of dividend.
  - Clear the remainder register; load the iteration counter with N = XLEN.
  - Next state is RUN, unless a special case applies.
- Special cases, resolved in IDLE, go directly to DONE:
  - b=0: quotient = all ones; remainder = a.
  - Signed op with a=0x80000000 and b=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- RUN, one restoring step per cycle:
  - {rem,quo} shifted left 1; trial = rem − |b|.
  - If trial ≥ 0, rem = trial and quo LSB = 1.
  - The counter decrements each step; when it reaches 0, go to FIX.
- FIX: negate the quotient if its sign is 1; negate the remainder if the dividend sign is 1 (signed ops only). Select the quotient or remainder by funct3[1]. Register the result. Next state is DONE.
- DONE: done=1, result driven. Next state is IDLE unconditionally; a start_EX seen in DONE is ignored.
- stall_EX = (IDLE & start_EX & ~kill) | RUN | FIX.
- kill, in any state: next state is IDLE, no done pulse, stall_EX=0 in that cycle. kill has priority over start_EX.
- Reset values: state IDLE; stall_EX, busy, done = 0; result = 0; all datapath registers = 0.

## Timing
- Start is accepted at cycle 0. RUN occupies cycles 1..N, FIX is cycle N+1, and DONE is cycle N+2.
- For XLEN=32: done at cycle 34, stall_EX high for cycles 0..33.
- Special case: done at cycle 1, stall_EX high for cycle 0 only.
- Back-to-back divides: the second start is seen in the IDLE cycle after DONE, so there are no bubbles beyond the normal latency.
- Operand changes after cycle 0 are ignored.
- rst_n asserted mid-operation drives all outputs to their reset values immediately, with no clock required.

## Configuration
- DIV_RADIX4_EN defined: two restoring steps per RUN cycle and N = XLEN/2. For XLEN=32, done arrives at cycle 18 and stall_EX is high for cycles 0..17.
- Undefined: one step per cycle as specified above.
- Results are bit-identical either way; special-case latency is unchanged.

## Structure
- The shared package riscv_pkg holds:
  - the funct3 divide encodings (F3_DIV, F3_DIVU, F3_REM, F3_REMU);
  - the OP_RTYPE and FUNCT7_MULDIV constants;
  - the div_state_t enum;
  - XLEN_DEFAULT.
- Sub-module div_step: purely combinational single restoring step. Inputs are {rem,quo} and the divisor; outputs are the next {rem,quo}. Instantiated once, or chained twice under DIV_RADIX4_EN.

## Test plan
- DIVU a=100, b=7 → done at cycle 34 (18 with macro), result=14. REMU with the same operands → 2.
- DIV a=0xFFFFFFF9 (−7), b=2 → result 0xFFFFFFFD (−3). REM with the same operands → 0xFFFFFFFF (−1).
- DIV a=5, b=0 → done at cycle 1, result 0xFFFFFFFF. REMU a=5, b=0 → result 5.
- DIV a=0x80000000, b=0xFFFFFFFF → done at cycle 1, result 0x80000000. REM with the same operands → 0.
- Start DIVU 100/7, then kill at cycle 10:
  - cycle 10: stall_EX=0;
  - cycle 11: busy=0;
  - no done pulse ever;
  - a new DIVU 9/3 then yields result 3 at its own cycle 34.
- Assert rst_n low at cycle 20 of a DIV → stall_EX, busy, done and result read 0 before the next clock edge. After release, a new DIVU 100/7 completes normally.
